// File: rtl/frame_accumulator_pkg.sv
// rtl/frame_accumulator_pkg.sv - shared types for the progressive-render frame accumulator
package frame_accumulator_pkg;

  // Address width for the default 320x180 framebuffer
  localparam int FB_ADDR_W = $clog2(320 * 180);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color8;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

endpackage

// File: rtl/frame_accumulator_if.sv
// rtl/frame_accumulator_if.sv - traced pixel stream from ray_tracer into the accumulator
interface frame_accumulator_if;
  import frame_accumulator_pkg::*;

  color8       pixel_color;
  logic [10:0] pixel_h;
  logic [9:0]  pixel_v;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_color, pixel_h, pixel_v, pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_color, pixel_h, pixel_v, pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/fb_dual_port_ram.sv
// rtl/fb_dual_port_ram.sv - framebuffer RAM: read-first write-side port A, 1-cycle display read port B
module fb_dual_port_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Read-first: a same-address write this cycle is not visible on a_rdata until next read
  always_ff @(posedge clk) begin
    if (a_we) begin
      r_mem[a_waddr] <= a_wdata;
    end
    a_rdata <= r_mem[a_raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_rdata <= '0;
    end else begin
      b_rdata <= r_mem[b_addr];
    end
  end

endmodule

// File: rtl/frame_accumulator.sv
// rtl/frame_accumulator.sv - blends traced pixels into a per-pixel framebuffer, tracks frames
// FRAME_ACC_ROUND_EN: round-half-up blend step instead of floor.
module frame_accumulator
  import frame_accumulator_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 180,
  parameter int BLEND_SHIFT = 2,
  parameter int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  frame_accumulator_if.slave  pix,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rd_addr,
  output color8               rd_color,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                clearing
);

  localparam int                DEPTH      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [10:0]       H_LIM      = 11'(WIDTH);
  localparam logic [9:0]        V_LIM      = 10'(HEIGHT);
  localparam logic [21:0]       ROW_STRIDE = 22'(WIDTH);
`ifdef FRAME_ACC_ROUND_EN
  localparam logic signed [9:0] ROUND_BIAS = 10'(1 << (BLEND_SHIFT - 1));
`endif

  fb_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, r_pix_cnt, r_s1_addr, w_s0_addr, w_a_waddr;
  logic [21:0]       w_lin;
  logic              w_in_range, w_accept, w_s1_write, w_a_we;
  logic              r_s1_valid, r_s1_we, r_s1_first, r_fwd, r_first_frame, r_frame_done;
  logic [15:0]       r_frame_count;
  color8             r_s1_color, r_fwd_data, w_ram_old, w_old, w_blend, w_a_wdata, w_rd_data;
  logic signed [9:0] w_sum_r, w_sum_g, w_sum_b;

  // 10-bit signed so the rounding bias cannot overflow the difference
  function automatic logic signed [9:0] blend_ch(input logic [7:0] old_c, input logic [7:0] in_c);
    logic signed [9:0] d;
    d = $signed({2'b00, in_c}) - $signed({2'b00, old_c});
`ifdef FRAME_ACC_ROUND_EN
    d = d + ROUND_BIAS;
`endif
    return $signed({2'b00, old_c}) + (d >>> BLEND_SHIFT);
  endfunction

  assign pix.pixel_ready = (r_state == RUN) && !clear;
  assign w_accept        = pix.pixel_valid && pix.pixel_ready;
  assign w_lin           = 22'(pix.pixel_v) * ROW_STRIDE + 22'(pix.pixel_h);
  assign w_s0_addr       = w_lin[ADDR_W-1:0];
  assign w_in_range      = (pix.pixel_h < H_LIM) && (pix.pixel_v < V_LIM);
  assign w_s1_write      = r_s1_valid && r_s1_we;

  assign rd_color    = w_rd_data;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign clearing    = (r_state == CLEAR);

  always_comb begin
    w_old   = r_fwd ? r_fwd_data : w_ram_old;
    w_sum_r = blend_ch(w_old.r, r_s1_color.r);
    w_sum_g = blend_ch(w_old.g, r_s1_color.g);
    w_sum_b = blend_ch(w_old.b, r_s1_color.b);
    w_blend = r_s1_color;
    if (!r_s1_first) begin
      w_blend.r = w_sum_r[7:0];
      w_blend.g = w_sum_g[7:0];
      w_blend.b = w_sum_b[7:0];
    end
  end

  always_comb begin
    w_a_we    = w_s1_write;
    w_a_waddr = r_s1_addr;
    w_a_wdata = w_blend;
    if (r_state == CLEAR) begin
      w_a_we    = 1'b1;
      w_a_waddr = r_clr_addr;
      w_a_wdata = '0;
    end
  end

  fb_dual_port_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (24)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_raddr (w_s0_addr),
    .a_rdata (w_ram_old),
    .a_we    (w_a_we),
    .a_waddr (w_a_waddr),
    .a_wdata (w_a_wdata),
    .b_addr  (rd_addr),
    .b_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (!clear && r_clr_addr == LAST_ADDR) w_state_nxt = RUN;
      RUN:     if (clear) w_state_nxt = DRAIN;
      DRAIN:   if (!r_s1_valid) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_addr    <= '0;
      r_pix_cnt     <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_we       <= 1'b0;
      r_s1_first    <= 1'b0;
      r_s1_addr     <= '0;
      r_s1_color    <= '0;
      r_fwd         <= 1'b0;
      r_fwd_data    <= '0;
      r_first_frame <= 1'b1;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_s1_valid   <= w_accept;
      if (w_accept) begin
        r_s1_we    <= w_in_range;
        r_s1_addr  <= w_s0_addr;
        r_s1_color <= pix.pixel_color;
        r_s1_first <= r_first_frame;
      end
      // The RAM read issued this cycle misses the S1 write to the same address
      r_fwd      <= w_accept && w_s1_write && (w_s0_addr == r_s1_addr);
      r_fwd_data <= w_blend;

      if (r_state == CLEAR) begin
        r_clr_addr    <= (clear || r_clr_addr == LAST_ADDR) ? '0 : r_clr_addr + 1'b1;
        r_first_frame <= 1'b1;
        r_frame_count <= '0;
        r_pix_cnt     <= '0;
      end else begin
        r_clr_addr <= '0;
        if (w_accept) begin
          if (r_pix_cnt == LAST_ADDR) begin
            r_pix_cnt     <= '0;
            r_frame_done  <= 1'b1;
            r_first_frame <= 1'b0;
            if (r_frame_count != 16'hFFFF) begin
              r_frame_count <= r_frame_count + 16'd1;
            end
          end else begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
        end
      end
    end
  end

  a_blend_range: assert property (@(posedge clk) disable iff (!rst)
    (w_s1_write && !r_s1_first) |->
      (w_sum_r[9:8] == 2'b00 && w_sum_g[9:8] == 2'b00 && w_sum_b[9:8] == 2'b00));

endmodule

// File: tb/tb_frame_accumulator.sv
// tb/tb_frame_accumulator.sv - directed bench for frame_accumulator at 4x2, BLEND_SHIFT=2
module tb_frame_accumulator;
  import frame_accumulator_pkg::*;

`ifdef FRAME_ACC_ROUND_EN
  localparam logic [23:0] EXP_F1_P5 = 24'h964B26;
  localparam logic [23:0] EXP_F1_P0 = 24'h404040;
  localparam logic [23:0] EXP_F2_P5 = 24'h552A16;
`else
  localparam logic [23:0] EXP_F1_P5 = 24'h964B25;
  localparam logic [23:0] EXP_F1_P0 = 24'h3F3F3F;
  localparam logic [23:0] EXP_F2_P5 = 24'h542A14;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  rd_addr = '0;
  color8       rd_color;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        clearing;
  int          checks = 0;
  int          errors = 0;
  int          done_pulses = 0;
  int          n;

  frame_accumulator_if pix();

  frame_accumulator #(
    .WIDTH       (4),
    .HEIGHT      (2),
    .BLEND_SHIFT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pix),
    .clear       (clear),
    .rd_addr     (rd_addr),
    .rd_color    (rd_color),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .clearing    (clearing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int h, input int v, input logic [23:0] c);
    bit ok = 1'b0;
    @(negedge clk);
    pix.pixel_h     = 11'(h);
    pix.pixel_v     = 10'(v);
    pix.pixel_color = c;
    pix.pixel_valid = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (pix.pixel_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    pix.pixel_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [23:0] exp);
    @(negedge clk);
    rd_addr = 3'(addr);
    @(negedge clk);
    check(tag, 32'(rd_color), 32'(exp));
  endtask

  task automatic ready_latency(input string tag);
    int cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (pix.pixel_ready) break;
    end
    check(tag, 32'(cyc), 32'd8);
  endtask

  initial begin
    pix.pixel_valid = 1'b0;
    pix.pixel_h     = '0;
    pix.pixel_v     = '0;
    pix.pixel_color = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(pix.pixel_ready), 32'd0);
    check("rst_clearing", 32'(clearing), 32'd1);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_rd_color", 32'(rd_color), 32'd0);
    rst = 1'b1;
    ready_latency("sweep_len");
    check("run_clearing", 32'(clearing), 32'd0);
    for (int a = 0; a < 8; a++) read_chk("swept_zero", a, 24'h000000);

    // Frame 0: first frame is written directly
    for (int a = 0; a < 8; a++)
      send(a % 4, a / 4, (a == 5) ? 24'hC86432 : {8'(a * 16), 8'(a * 8), 8'(a)});
    idle();
    repeat (3) @(negedge clk);
    check("f0_pulses", 32'(done_pulses), 32'd1);
    check("f0_count", 32'(frame_count), 32'd1);
    read_chk("f0_p5", 5, 24'hC86432);
    read_chk("f0_p4", 4, 24'h402004);
    read_chk("f0_p2", 2, 24'h201002);

    // Frame 1: blend, out-of-range beat aliasing addr 4, repeated addr 2
    send(1, 1, 24'h000000);
    send(0, 0, 24'hFFFFFF);
    send(4, 0, 24'h000000);
    for (int i = 0; i < 5; i++) send(2, 0, 24'h201002);
    idle();
    repeat (3) @(negedge clk);
    check("f1_pulses", 32'(done_pulses), 32'd2);
    check("f1_count", 32'(frame_count), 32'd2);
    read_chk("f1_p5", 5, EXP_F1_P5);
    read_chk("f1_p0", 0, EXP_F1_P0);
    read_chk("f1_p4_oor", 4, 24'h402004);
    read_chk("f1_p2", 2, 24'h201002);

    // Frame 2: back-to-back same address exercises forwarding
    send(1, 1, 24'h000000);
    send(1, 1, 24'h000000);
    for (int i = 0; i < 6; i++) send(4, 1, 24'h000000);
    idle();
    repeat (3) @(negedge clk);
    check("f2_count", 32'(frame_count), 32'd3);
    read_chk("f2_p5_fwd", 5, EXP_F2_P5);
    read_chk("f2_p0_oor", 0, EXP_F1_P0);

    // Clear mid-frame with valid held high
    send(3, 0, 24'h0A141E);
    send(3, 0, 24'h0A141E);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(pix.pixel_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    pix.pixel_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (pix.pixel_ready) break;
      if (clearing) n++;
      @(negedge clk);
    end
    check("clr_sweep_len", 32'(n), 32'd8);
    check("clr_count", 32'(frame_count), 32'd0);
    check("clr_pulses", 32'(done_pulses), 32'd3);
    read_chk("clr_p3", 3, 24'h000000);
    read_chk("clr_p5", 5, 24'h000000);

    // After clear the first frame is direct again and pix_cnt restarted
    for (int a = 0; a < 8; a++) send(a % 4, a / 4, (a == 5) ? 24'h090807 : 24'h010101);
    idle();
    repeat (3) @(negedge clk);
    check("f4_pulses", 32'(done_pulses), 32'd4);
    check("f4_count", 32'(frame_count), 32'd1);
    read_chk("f4_p5", 5, 24'h090807);

    // Async reset in the middle of a sweep
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_clearing", 32'(clearing), 32'd1);
    check("mid_rd_color", 32'(rd_color), 32'h090807);
    #2;
    rst = 1'b0;
    #1;
    check("arst_rd_color", 32'(rd_color), 32'd0);
    check("arst_ready", 32'(pix.pixel_ready), 32'd0);
    check("arst_clearing", 32'(clearing), 32'd1);
    check("arst_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ready_latency("arst_sweep_len");
    read_chk("arst_p5", 5, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
